// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite master with per-transaction timeout
module axi4_lite_master #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_timeout,
    output logic                    o_awvalid,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    input  logic                    i_awready,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_AD   = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RESPOND = 3'd5;

    localparam int              CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;

    // Address/data completion: a channel is done once its valid has dropped
    // or its handshake lands this cycle.
    logic aw_hs;
    logic w_hs;
    logic aw_done;
    logic w_done;

    assign aw_hs   = o_awvalid && i_awready;
    assign w_hs    = o_wvalid && i_wready;
    assign aw_done = !o_awvalid || aw_hs;
    assign w_done  = !o_wvalid || w_hs;

    // Transaction sequencer; busy states share the timeout check, which wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            o_cmd_ready   <= 1'b0;
            o_rsp_valid   <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_resp    <= 2'b00;
            o_rsp_timeout <= 1'b0;
            o_awvalid     <= 1'b0;
            o_awaddr      <= '0;
            o_wvalid      <= 1'b0;
            o_wstrb       <= '0;
            o_wdata       <= '0;
            o_bready      <= 1'b0;
            o_arvalid     <= 1'b0;
            o_araddr      <= '0;
            o_rready      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (o_cmd_ready && i_cmd_valid) begin
                        o_cmd_ready   <= 1'b0;
                        cnt           <= '0;
                        o_rsp_timeout <= 1'b0;
                        if (i_cmd_write) begin
                            o_awaddr  <= i_cmd_addr;
                            o_wdata   <= i_cmd_data;
                            o_wstrb   <= i_cmd_strb;
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            state     <= S_WR_AD;
                        end else begin
                            o_araddr  <= i_cmd_addr;
                            o_arvalid <= 1'b1;
                            state     <= S_RD_ADDR;
                        end
                    end else begin
                        o_cmd_ready <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    if (cnt == TO_LAST) begin
                        o_awvalid     <= 1'b0;
                        o_wvalid      <= 1'b0;
                        o_bready      <= 1'b0;
                        o_arvalid     <= 1'b0;
                        o_rready      <= 1'b0;
                        o_rsp_resp    <= 2'b10;
                        o_rsp_timeout <= 1'b1;
                        o_rsp_data    <= '0;
                        o_rsp_valid   <= 1'b1;
                        state         <= S_RESPOND;
                    end else begin
                        cnt <= cnt + 1'b1;
                        case (state)
                            S_WR_AD: begin
                                if (aw_hs) o_awvalid <= 1'b0;
                                if (w_hs)  o_wvalid  <= 1'b0;
                                if (aw_done && w_done) begin
                                    o_bready <= 1'b1;
                                    state    <= S_WR_RESP;
                                end
                            end
                            S_WR_RESP: begin
                                if (i_bvalid && o_bready) begin
                                    o_bready    <= 1'b0;
                                    o_rsp_resp  <= i_bresp;
                                    o_rsp_data  <= '0;
                                    o_rsp_valid <= 1'b1;
                                    state       <= S_RESPOND;
                                end
                            end
                            S_RD_ADDR: begin
                                if (o_arvalid && i_arready) begin
                                    o_arvalid <= 1'b0;
                                    o_rready  <= 1'b1;
                                    state     <= S_RD_DATA;
                                end
                            end
                            S_RD_DATA: begin
                                if (i_rvalid && o_rready) begin
                                    o_rready    <= 1'b0;
                                    o_rsp_resp  <= i_rresp;
                                    o_rsp_data  <= i_rdata;
                                    o_rsp_valid <= 1'b1;
                                    state       <= S_RESPOND;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
Single-outstanding AXI4-Lite master that converts a simple command/response interface into AXI4-Lite read and write transactions. It sits directly upstream of the team's AXI4-Lite register slaves, for example the demo control/status slave. Host-side logic, such as a command parser or test controller, drives it. It includes a per-transaction timeout, so a dead or missing slave can never hang the host.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width
STROBE_WIDTH, DATA_WIDTH/8, write strobe width
TIMEOUT, 256, bus cycles allowed per transaction before abort (must be >= 2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_cmd_valid  input  1  command present
o_cmd_ready  output  1  master can accept a command
i_cmd_write  input  1  1 = write, 0 = read
i_cmd_addr  input  ADDR_WIDTH  target address
i_cmd_data  input  DATA_WIDTH  write data
i_cmd_strb  input  STROBE_WIDTH  write strobes
o_rsp_valid  output  1  response present
i_rsp_ready  input  1  host accepts response
o_rsp_data  output  DATA_WIDTH  read data (0 for writes)
o_rsp_resp  output  2  AXI response code
o_rsp_timeout  output  1  transaction aborted by timeout
o_awvalid  output  1  AW valid
o_awaddr  output  ADDR_WIDTH  AW address
i_awready  input  1  AW ready
o_wvalid  output  1  W valid
i_wready  input  1  W ready
o_wstrb  output  STROBE_WIDTH  W strobes
o_wdata  output  DATA_WIDTH  W data
i_bvalid  input  1  B valid
o_bready  output  1  B ready
i_bresp  input  2  B response
o_arvalid  output  1  AR valid
i_arready  input  1  AR ready
o_araddr  output  ADDR_WIDTH  AR address
i_rvalid  input  1  R valid
o_rready  output  1  R ready
i_rresp  input  2  R response
i_rdata  input  DATA_WIDTH  R data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs registered and 0; o_cmd_ready=0; state=IDLE. o_cmd_ready rises on the first cycle after reset deasserts.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid&&o_cmd_ready, latch address, data and strobes; drop o_cmd_ready; clear the timeout counter.
  - Write command: assert o_awvalid and o_wvalid on the next cycle and go to WR_ADDR_DATA.
  - Read command: assert o_arvalid and go to RD_ADDR.
- WR_ADDR_DATA:
  - o_awvalid and o_wvalid are held independently until each sees its ready; each drops the cycle after its handshake.
  - Address and data may complete in either order or in the same cycle.
  - Payloads stay stable while valid is high.
  - When both have completed, assert o_bready and go to WR_RESP.
- WR_RESP: on i_bvalid&&o_bready, capture i_bresp, set o_rsp_data=0, drop o_bready, go to RESPOND.
- RD_ADDR: hold o_arvalid until i_arready. Then drop o_arvalid, assert o_rready, go to RD_DATA.
- RD_DATA: on i_rvalid&&o_rready, capture i_rdata and i_rresp, drop o_rready, go to RESPOND.
- RESPOND:
  - o_rsp_valid=1 with data, resp and timeout held stable until i_rsp_ready.
  - On handshake, drop o_rsp_valid, return to IDLE, and raise o_cmd_ready on the next cycle.
- Minimum command-to-response latency against a zero-wait slave: write 3 cycles from the accept edge to o_rsp_valid; read 3 cycles.
- Timeout:
  - Counter increments every cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA.
  - On reaching TIMEOUT-1, force all AXI valid/ready outputs to 0 and set o_rsp_resp=2'b10 (SLVERR), o_rsp_timeout=1, o_rsp_data=0, then go to RESPOND.
  - The timeout has priority over a handshake completing in the same cycle.
  - The counter is cleared on every command accept.
- Only one transaction is outstanding at a time. Commands are never accepted outside IDLE.
- Response codes are passed through unchanged: OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11. o_rsp_timeout=0 unless the transaction aborted.
- Reset mid-transaction: all valid/ready outputs drop in the cycle rst is sampled. Any pending response is discarded.

Test Plan:
- Write 0xDEADBEEF, strb 4'hF, to addr 0 of the demo slave -> AW and W handshake, bresp 00; o_rsp_valid with resp 00, data 0, timeout 0.
- Read addr 0 after that write -> o_araddr=0; o_rsp_data=0xDEADBEEF, resp 00. Read addr 5 -> resp 11, data 0.
- Write to addr 1 (read-only status) -> o_rsp_resp=11 (DECERR), o_rsp_timeout=0.
- Slave stub accepts W two cycles before AW, then answers B after 4 cycles -> awvalid/wvalid drop independently; single response with the stub's bresp; no duplicate AW or W.
- TIMEOUT=16, stub never asserts arready -> o_arvalid held exactly 16 cycles, then low; o_rsp_resp=10, o_rsp_timeout=1; next command accepted normally.
- Hold i_rsp_ready=0 for 10 cycles in RESPOND -> response stable, o_cmd_ready=0 throughout. Assert rst during RD_DATA -> all outputs 0 on the next edge; o_cmd_ready=1 one cycle after reset release.
